trace_wb_buf: RTL and testbench
===============================

TRACE_WB_BUF -- requirements
Module: trace_wb_buf

Interface
REQ-001 Parameter: DEPTH, 8, number of FIFO entries; a power of two, at least 2.
REQ-002 Parameter: AW, 3, pointer width, equal to log2(DEPTH).
REQ-003 tb_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 tb_rst  in  1  reset, synchronous, active-high.
REQ-005 wb_have_inc  in  1  WB stage retires an instruction this cycle.
REQ-006 wb_pc  in  32  PC of the retiring instruction.
REQ-007 wb_ena  in  1  register writeback enable of the retiring instruction.
REQ-008 wb_reg  in  5  destination register (r1 for PC4_R1 type).
REQ-009 wb_value  in  32  writeback data, already muxed by the register file.
REQ-010 out_valid  out  1  head entry is available.
REQ-011 out_ready  in  1  consumer accepts the head entry.
REQ-012 out_pc  out  32  head entry PC.
REQ-013 out_we  out  1  head entry write-enable.
REQ-014 out_reg  out  5  head entry destination register.
REQ-015 out_value  out  32  head entry value.
REQ-016 tb_count  out  AW+1  number of occupied entries, 0..DEPTH.
REQ-017 tb_full  out  1  high when tb_count == DEPTH.
REQ-018 tb_ovf  out  1  sticky flag: at least one retire event was dropped.
REQ-019 tb_drop_cnt  out  16  number of dropped events; saturates at 16'hFFFF.

Function
REQ-020 push = wb_have_inc; pop = out_valid & out_ready; a cycle with wb_have_inc low SHALL NOT write the FIFO.
REQ-021 Each pushed entry SHALL store {wb_pc, we, reg, value}:
- we = wb_ena & (wb_reg != 0).
- reg = wb_reg.
- value = 0 when we == 0, otherwise wb_value (r0 never reports nonzero data).
REQ-022 The FIFO is circular:
- wr_ptr advances by 1 on each accepted push, rd_ptr advances by 1 on each pop.
- Both pointers wrap from DEPTH-1 to 0.
- tb_count SHALL be +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-023 out_valid SHALL equal (tb_count != 0).
- out_pc, out_we, out_reg and out_value SHALL show the entry at rd_ptr when out_valid is 1, and all zero when out_valid is 0.
REQ-024 Latency: an entry pushed in cycle N SHALL appear at the head (out_valid = 1 if the FIFO was empty) in cycle N+1; there is no combinational fall-through.
REQ-025 Entries SHALL leave the FIFO in push order with no duplication and no loss, except for drops under REQ-027.
REQ-026 Push while empty with out_ready = 1 SHALL NOT pop in the same cycle, because out_valid is still 0.
REQ-027 Push while full:
- If a pop also occurs, the push SHALL be accepted and tb_count stays DEPTH.
- If no pop occurs, the event SHALL be dropped, memory and wr_ptr stay unchanged, tb_ovf is set to 1, and tb_drop_cnt increments unless it is saturated.
REQ-028 Pop with out_ready = 1 while empty SHALL have no effect.
REQ-029 tb_ovf and tb_drop_cnt SHALL clear only on reset.
REQ-030 The block SHALL NOT backpressure the pipeline; it is observation-only and has no stall output.

Reset
REQ-031 While tb_rst is high at a rising edge, the block SHALL clear:
- wr_ptr, rd_ptr and tb_count to 0.
- tb_ovf to 0 and tb_drop_cnt to 0.
REQ-032 After reset: out_valid = 0, out_* = 0 and tb_full = 0.
- Storage contents need not be cleared.
REQ-033 Reset SHALL take priority over a simultaneous push or pop; that push is discarded.
REQ-034 Reset mid-operation SHALL discard all buffered entries; the first push after reset is the head entry in the following cycle.

Verification
REQ-035 Reset, then push pc=0x1c000000, ena=1, reg=5, value=0x12345678 with out_ready=0 -> next cycle out_valid=1, out_pc=0x1c000000, out_we=1, out_reg=5, out_value=0x12345678, tb_count=1.
REQ-036 Push reg=0, ena=1, value=0xDEADBEEF -> the entry reads out_we=0, out_value=0.
REQ-037 With out_ready=0, push 10 events (DEPTH=8) -> tb_full=1, tb_count=8, tb_ovf=1, tb_drop_cnt=2; draining yields the first 8 PCs in order.
REQ-038 Fill to 8, then push and pop in the same cycle -> tb_count stays 8, tb_ovf unchanged, the new entry emerges last; continuous push+pop for 20 cycles wraps the pointers with no loss.
REQ-039 Fill with 3 entries, assert tb_rst for 1 cycle along with a push -> tb_count=0, out_valid=0, tb_ovf=0; a push on the next cycle appears alone at the head.

Source files
------------

// File: rtl/trace_wb_buf.sv
`default_nettype none
// ============================================================================
// Module      : trace_wb_buf
// Description : Observation-only trace buffer for retired writeback events.
//               Circular FIFO with registered head output, drop-on-full
//               behaviour, a sticky overflow flag and a saturating drop count.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_wb_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          tb_clk,
    input  logic          tb_rst,
    input  logic          wb_have_inc,
    input  logic [31:0]   wb_pc,
    input  logic          wb_ena,
    input  logic [4:0]    wb_reg,
    input  logic [31:0]   wb_value,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic          out_we,
    output logic [4:0]    out_reg,
    output logic [31:0]   out_value,
    output logic [AW:0]   tb_count,
    output logic          tb_full,
    output logic          tb_ovf,
    output logic [15:0]   tb_drop_cnt
);

    // Entry layout: {pc[31:0], we, reg[4:0], value[31:0]}
    localparam int            c_ENTRY_W = 70;
    localparam logic [AW:0]   c_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
    localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic                 r_ovf;
    logic [15:0]          r_drop_cnt;

    logic                 w_valid;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_we;
    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_ENTRY_W-1:0] w_head;

    // Handshake decode; a push into a full FIFO is only accepted when the
    // head leaves in the same cycle, so no event is ever overwritten.
    always_comb begin
        w_valid  = (r_count != '0);
        w_full   = (r_count == c_DEPTH);
        w_pop    = w_valid & out_ready;
        w_accept = wb_have_inc & (~w_full | w_pop);
        w_drop   = wb_have_inc & w_full & ~w_pop;
        // r0 writes are reported as non-writes with zero data
        w_we     = wb_ena & (wb_reg != 5'd0);
        w_entry  = {wb_pc, w_we, wb_reg, (w_we ? wb_value : 32'd0)};
        w_head   = r_mem[r_rd_ptr];
    end

    // Entry storage; not reset since occupancy is tracked by r_count.
    always_ff @(posedge tb_clk) begin
        if (!tb_rst && w_accept) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge tb_clk) begin
        if (tb_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge tb_clk) begin
        if (tb_rst) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= 16'd0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Head presentation; all fields forced to zero while empty.
    always_comb begin
        out_valid   = w_valid;
        out_pc      = w_valid ? w_head[69:38] : 32'd0;
        out_we      = w_valid ? w_head[37]    : 1'b0;
        out_reg     = w_valid ? w_head[36:32] : 5'd0;
        out_value   = w_valid ? w_head[31:0]  : 32'd0;
        tb_count    = r_count;
        tb_full     = w_full;
        tb_ovf      = r_ovf;
        tb_drop_cnt = r_drop_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_trace_wb_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_wb_buf
// Description : Directed self-checking bench for trace_wb_buf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_wb_buf;

    logic        tb_clk;
    logic        tb_rst;
    logic        wb_have_inc;
    logic [31:0] wb_pc;
    logic        wb_ena;
    logic [4:0]  wb_reg;
    logic [31:0] wb_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        out_we;
    logic [4:0]  out_reg;
    logic [31:0] out_value;
    logic [3:0]  tb_count;
    logic        tb_full;
    logic        tb_ovf;
    logic [15:0] tb_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q_exp[$];

    trace_wb_buf #(.DEPTH(8), .AW(3)) dut (
        .tb_clk      (tb_clk),
        .tb_rst      (tb_rst),
        .wb_have_inc (wb_have_inc),
        .wb_pc       (wb_pc),
        .wb_ena      (wb_ena),
        .wb_reg      (wb_reg),
        .wb_value    (wb_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_we      (out_we),
        .out_reg     (out_reg),
        .out_value   (out_value),
        .tb_count    (tb_count),
        .tb_full     (tb_full),
        .tb_ovf      (tb_ovf),
        .tb_drop_cnt (tb_drop_cnt)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 after the edge.
    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic drive(input logic inc, input logic [31:0] pc, input logic ena,
                         input logic [4:0] rg, input logic [31:0] val);
        wb_have_inc = inc;
        wb_pc       = pc;
        wb_ena      = ena;
        wb_reg      = rg;
        wb_value    = val;
    endtask

    initial begin
        tb_rst    = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        tb_rst = 1'b0;

        // Reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {28'd0, tb_count}, 32'd0);
        chk("rst_full",  {31'd0, tb_full}, 32'd0);
        chk("rst_ovf",   {31'd0, tb_ovf}, 32'd0);
        chk("rst_drop",  {16'd0, tb_drop_cnt}, 32'd0);
        chk("rst_pc",    out_pc, 32'd0);

        // Single push, visible next cycle
        drive(1'b1, 32'h1c000000, 1'b1, 5'd5, 32'h12345678);
        tick();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("p1_valid", {31'd0, out_valid}, 32'd1);
        chk("p1_pc",    out_pc, 32'h1c000000);
        chk("p1_we",    {31'd0, out_we}, 32'd1);
        chk("p1_reg",   {27'd0, out_reg}, 32'd5);
        chk("p1_value", out_value, 32'h12345678);
        chk("p1_count", {28'd0, tb_count}, 32'd1);

        // r0 write is reported as non-write with zero data
        drive(1'b1, 32'h00000100, 1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("r0_count", {28'd0, tb_count}, 32'd2);
        out_ready = 1'b1;
        tick();
        chk("r0_pc",    out_pc, 32'h00000100);
        chk("r0_we",    {31'd0, out_we}, 32'd0);
        chk("r0_value", out_value, 32'd0);
        chk("r0_count", {28'd0, tb_count}, 32'd1);
        tick();
        chk("empty_valid", {31'd0, out_valid}, 32'd0);
        chk("empty_pc",    out_pc, 32'd0);
        out_ready = 1'b0;

        // Overfill: 10 pushes into 8 entries
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 5'(i + 1), 32'hA0 + 32'(i));
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("ovf_count", {28'd0, tb_count}, 32'd8);
        chk("ovf_full",  {31'd0, tb_full}, 32'd1);
        chk("ovf_flag",  {31'd0, tb_ovf}, 32'd1);
        chk("ovf_drop",  {16'd0, tb_drop_cnt}, 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_pc",  out_pc, 32'h1000 + 32'(i * 4));
            chk("ovf_drain_val", out_value, 32'hA0 + 32'(i));
            tick();
        end
        chk("ovf_drained", {28'd0, tb_count}, 32'd0);
        out_ready = 1'b0;

        // Fill to 8, then push+pop every cycle (first at full)
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h2000 + 32'(i * 4), 1'b1, 5'd3, 32'd1);
            q_exp.push_back(32'h2000 + 32'(i * 4));
            tick();
        end
        chk("wrap_fill", {28'd0, tb_count}, 32'd8);
        out_ready = 1'b1;
        for (int k = 0; k < 21; k++) begin
            logic [31:0] npc;
            npc = (k == 0) ? 32'h3000 : 32'h4000 + 32'((k - 1) * 4);
            chk("wrap_head", out_pc, q_exp.pop_front());
            q_exp.push_back(npc);
            drive(1'b1, npc, 1'b1, 5'd3, 32'd1);
            tick();
            if (k == 0) begin
                chk("pp_full_count", {28'd0, tb_count}, 32'd8);
                chk("pp_full_drop",  {16'd0, tb_drop_cnt}, 32'd2);
            end
        end
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("wrap_count", {28'd0, tb_count}, 32'd8);
        chk("wrap_ovf",   {31'd0, tb_ovf}, 32'd1);
        chk("wrap_drop",  {16'd0, tb_drop_cnt}, 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_drain", out_pc, q_exp.pop_front());
            tick();
        end
        chk("wrap_empty", {28'd0, tb_count}, 32'd0);

        // Push while empty with ready high: no same-cycle pop
        drive(1'b1, 32'h5000, 1'b0, 5'd4, 32'h55);
        tick();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("pe_count", {28'd0, tb_count}, 32'd1);
        chk("pe_pc",    out_pc, 32'h5000);
        chk("pe_we",    {31'd0, out_we}, 32'd0);
        tick();
        chk("pe_popped", {28'd0, tb_count}, 32'd0);
        tick();
        chk("pop_empty_count", {28'd0, tb_count}, 32'd0);
        chk("pop_empty_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset mid-operation with a simultaneous push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h6000 + 32'(i * 4), 1'b1, 5'd2, 32'd9);
            tick();
        end
        chk("mr_fill", {28'd0, tb_count}, 32'd3);
        tb_rst = 1'b1;
        drive(1'b1, 32'h7000, 1'b1, 5'd2, 32'd9);
        tick();
        tb_rst = 1'b0;
        drive(1'b1, 32'h8000, 1'b1, 5'd6, 32'h66);
        chk("mr_count", {28'd0, tb_count}, 32'd0);
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_ovf",   {31'd0, tb_ovf}, 32'd0);
        chk("mr_drop",  {16'd0, tb_drop_cnt}, 32'd0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("mr_push_count", {28'd0, tb_count}, 32'd1);
        chk("mr_push_pc",    out_pc, 32'h8000);
        chk("mr_push_value", out_value, 32'h66);
        out_ready = 1'b1;
        tick();
        chk("mr_final", {28'd0, tb_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
